// File: rtl/cl_dma_seq_pkg.sv
// Shared types and field positions for the S2MM frame sequencer.
// Covers the FSM states, the DataMover status/command bit positions and the command builder.
package cl_dma_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CMD,
    WAIT_SOF,
    STREAM,
    WAIT_STS
  } seq_state_e;

  localparam int STS_OKAY    = 7;
  localparam int STS_SLVERR  = 6;
  localparam int STS_DECERR  = 5;
  localparam int STS_INTERR  = 4;
  localparam int STS_TAG_MSB = 3;
  localparam int STS_TAG_LSB = 0;

  localparam int CMD_W        = 72;
  localparam int CMD_TAG_LSB  = 64;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_DRR      = 31;
  localparam int CMD_EOF      = 30;
  localparam int CMD_DSA_LSB  = 24;
  localparam int CMD_TYPE     = 23;
  localparam int CMD_BTT_W    = 23;

  // DRR, DSA and the reserved top nibble stay zero; EOF and INCR are always set.
  function automatic logic [CMD_W-1:0] mk_s2mm_cmd(input logic [3:0]           tag,
                                                   input logic [31:0]          addr,
                                                   input logic [CMD_BTT_W-1:0] btt);
    logic [CMD_W-1:0] cmd;
    cmd                       = '0;
    cmd[CMD_TAG_LSB +: 4]     = tag;
    cmd[CMD_ADDR_LSB +: 32]   = addr;
    cmd[CMD_EOF]              = 1'b1;
    cmd[CMD_TYPE]             = 1'b1;
    cmd[CMD_BTT_W-1:0]        = btt;
    return cmd;
  endfunction

endpackage

// File: rtl/cl_dma_buf_ring.sv
// Frame-buffer ring: ownership bitmap, write pointer and buffer address generation.
// A claim of an index beats a simultaneous release or error-return of the same index.
module cl_dma_buf_ring
  import cl_dma_seq_pkg::*;
#(
  parameter  int NUM_BUF = 4,
  parameter  int ADDR_W  = 32,
  localparam int IW      = $clog2(NUM_BUF)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] buf_base_i,
  input  logic [ADDR_W-1:0] buf_stride_i,
  input  logic              claim_i,
  input  logic              advance_i,
  input  logic              release_i,
  input  logic [IW-1:0]     release_idx_i,
  input  logic              err_free_i,
  input  logic [IW-1:0]     err_free_idx_i,
  output logic [IW-1:0]     wr_ptr_o,
  output logic              ptr_free_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [NUM_BUF-1:0] free_q, free_d;
  logic [IW-1:0]      wr_ptr_q, wr_ptr_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    free_d   = free_q;
    wr_ptr_d = wr_ptr_q;
    if (release_i && int'(release_idx_i) < NUM_BUF) free_d[release_idx_i] = 1'b1;
    if (err_free_i) free_d[err_free_idx_i] = 1'b1;
    if (claim_i) free_d[wr_ptr_q] = 1'b0;
    if (advance_i) wr_ptr_d = (wr_ptr_q == IW'(NUM_BUF - 1)) ? '0 : wr_ptr_q + IW'(1);
  end

  // NOTE: the bitmap is small control state rather than a data RAM, so it takes the reset value.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      free_q   <= '1;
      wr_ptr_q <= '0;
    end else begin
      free_q   <= free_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign ptr_free_o = free_q[wr_ptr_q];
  assign addr_o     = buf_base_i + ADDR_W'(wr_ptr_q) * buf_stride_i;

endmodule

// File: rtl/cl_dma_frame_sequencer.sv
// Per-frame S2MM controller: arms the packer, issues one DataMover command per frame,
// gates pixel data for owned buffers and retires frames from the status stream.
module cl_dma_frame_sequencer
  import cl_dma_seq_pkg::*;
#(
  parameter  int NUM_BUF = 4,
  parameter  int ADDR_W  = 32,
  parameter  int BTT_W   = 23,
  localparam int IW      = $clog2(NUM_BUF)
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] buf_base,
  input  logic [ADDR_W-1:0] buf_stride,
  input  logic [BTT_W-1:0]  frame_bytes,
  input  logic              fval,
  output logic              frame_rst,
  output logic              data_gate,
  output logic [71:0]       cmd_tdata,
  output logic              cmd_tvalid,
  input  logic              cmd_tready,
  input  logic [7:0]        sts_tdata,
  input  logic              sts_tvalid,
  output logic              sts_tready,
  input  logic              buf_release,
  input  logic [IW-1:0]     buf_release_idx,
  output logic              frame_done,
  output logic              frame_err,
  output logic [IW-1:0]     done_idx,
  output logic [15:0]       drop_cnt
);

  seq_state_e        state_q;
  logic              fval_q;
  logic              frame_rst_q, data_gate_q, cmd_tvalid_q, sts_tready_q;
  logic              frame_done_q, frame_err_q;
  logic [71:0]       cmd_tdata_q;
  logic [IW-1:0]     done_idx_q;
  logic [15:0]       drop_cnt_q;

  logic [IW-1:0]     wr_ptr;
  logic              ptr_free;
  logic [ADDR_W-1:0] ring_addr;

  logic              sof, sts_hs, sts_ok, err_free, drop_event;
  logic [3:0]        sts_tag;

  assign sof        = fval & ~fval_q;
  assign sts_tag    = sts_tdata[STS_TAG_MSB:STS_TAG_LSB];
  assign sts_hs     = (state_q == WAIT_STS) & sts_tvalid & sts_tready_q;
  assign sts_ok     = sts_tdata[STS_OKAY] & ~sts_tdata[STS_SLVERR] & ~sts_tdata[STS_DECERR]
                    & ~sts_tdata[STS_INTERR] & (sts_tag == 4'(wr_ptr));
  // A bad status hands the tagged buffer back; tags outside the ring are ignored.
  assign err_free   = sts_hs & ~sts_ok & (int'(sts_tag) < NUM_BUF);
  assign drop_event = sof & (state_q inside {IDLE, ARM, CMD, WAIT_STS});

  cl_dma_buf_ring #(
    .NUM_BUF (NUM_BUF),
    .ADDR_W  (ADDR_W)
  ) u_ring (
    .sys_clk        (sys_clk),
    .reset          (reset),
    .buf_base_i     (buf_base),
    .buf_stride_i   (buf_stride),
    .claim_i        (state_q == ARM),
    .advance_i      (sts_hs),
    .release_i      (buf_release),
    .release_idx_i  (buf_release_idx),
    .err_free_i     (err_free),
    .err_free_idx_i (sts_tag[IW-1:0]),
    .wr_ptr_o       (wr_ptr),
    .ptr_free_o     (ptr_free),
    .addr_o         (ring_addr)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fval_q       <= 1'b0;
      frame_rst_q  <= 1'b0;
      data_gate_q  <= 1'b0;
      cmd_tdata_q  <= '0;
      cmd_tvalid_q <= 1'b0;
      sts_tready_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      done_idx_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      fval_q       <= fval;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (drop_event && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;

      case (state_q)
        IDLE: begin
          if (enable && ptr_free) begin
            frame_rst_q <= 1'b1;
            state_q     <= ARM;
          end
        end
        ARM: begin
          frame_rst_q  <= 1'b0;
          cmd_tdata_q  <= mk_s2mm_cmd(4'(wr_ptr), 32'(ring_addr), CMD_BTT_W'(frame_bytes));
          cmd_tvalid_q <= 1'b1;
          state_q      <= CMD;
        end
        CMD: begin
          if (cmd_tready) begin
            cmd_tvalid_q <= 1'b0;
            state_q      <= WAIT_SOF;
          end
        end
        // Only a fresh rising edge starts a frame; one already in flight is skipped.
        WAIT_SOF: begin
          if (sof) begin
            data_gate_q <= 1'b1;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (!fval) begin
            data_gate_q  <= 1'b0;
            sts_tready_q <= 1'b1;
            state_q      <= WAIT_STS;
          end
        end
        WAIT_STS: begin
          if (sts_tvalid) begin
            sts_tready_q <= 1'b0;
            frame_done_q <= sts_ok;
            frame_err_q  <= ~sts_ok;
            done_idx_q   <= wr_ptr;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_rst  = frame_rst_q;
  assign data_gate  = data_gate_q;
  assign cmd_tdata  = cmd_tdata_q;
  assign cmd_tvalid = cmd_tvalid_q;
  assign sts_tready = sts_tready_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign done_idx   = done_idx_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
